// File: rtl/bus_arb2.sv
// Two-master round-robin bus arbiter with a single slave port.
// Each transaction runs through IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> ACK.
// Every output comes from a register or is decoded from state plus registers.
module bus_arb2 #(
  parameter int unsigned DATAW  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_m0_req,
  input  logic             i_m0_we,
  input  logic [7:0]       i_m0_addr,
  input  logic [DATAW-1:0] i_m0_data,
  input  logic             i_m1_req,
  input  logic             i_m1_we,
  input  logic [7:0]       i_m1_addr,
  input  logic [DATAW-1:0] i_m1_data,
  output logic             o_m0_ack,
  output logic [DATAW-1:0] o_m0_data,
  output logic             o_m1_ack,
  output logic [DATAW-1:0] o_m1_data,
  output logic             o_we,
  output logic [7:0]       o_addr,
  output logic [DATAW-1:0] o_data,
  input  logic [DATAW-1:0] i_data,
  output logic             o_busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [DATAW-1:0] cmd_data;
  logic             gnt;        // granted master; doubles as last-granted history
  logic [CW-1:0]    wait_cnt;
  logic [DATAW-1:0] m0_rdata;
  logic [DATAW-1:0] m1_rdata;
  logic             any_req;
  logic             pick;
  logic             wait_done;

  // Round-robin choice: on contention prefer the master not granted last.
  always_comb begin
    any_req   = i_m0_req | i_m1_req;
    wait_done = (wait_cnt == CW'(RD_LAT - 1));
    if (i_m0_req && i_m1_req) begin
      pick = ~gnt;
    end else if (i_m0_req) begin
      pick = 1'b0;
    end else begin
      pick = 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = cmd_we ? S_ACK : S_WAIT;
      S_WAIT:  if (wait_done) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch, grant history, wait counter and read-data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      gnt      <= 1'b1;
      wait_cnt <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        gnt      <= pick;
        cmd_we   <= pick ? i_m1_we   : i_m0_we;
        cmd_addr <= pick ? i_m1_addr : i_m0_addr;
        cmd_data <= pick ? i_m1_data : i_m0_data;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT && !wait_done) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (state == S_WAIT && wait_done) begin
        if (gnt) begin
          m1_rdata <= i_data;
        end else begin
          m0_rdata <= i_data;
        end
      end
    end
  end

  assign o_we      = (state == S_ISSUE) && cmd_we;
  assign o_addr    = cmd_addr;
  assign o_data    = cmd_data;
  assign o_busy    = (state != S_IDLE);
  assign o_m0_ack  = (state == S_ACK) && !gnt;
  assign o_m1_ack  = (state == S_ACK) && gnt;
  assign o_m0_data = m0_rdata;
  assign o_m1_data = m1_rdata;

endmodule

// File: tb/tb_bus_arb2.sv
// Directed bench for bus_arb2: one instance with RD_LAT=1 behind a
// five-register slave model, one with RD_LAT=3 whose read data is driven
// cycle by cycle from the bench.
module tb_bus_arb2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- RD_LAT = 1 instance ----------------
  logic       rst1;
  logic       a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [7:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic       a_m0_ack, a_m1_ack, a_we, a_busy;
  logic [7:0] a_m0_rdata, a_m1_rdata, a_addr, a_odata, a_idata;

  bus_arb2 #(.DATAW(8), .RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst1),
    .i_m0_req(a_m0_req), .i_m0_we(a_m0_we), .i_m0_addr(a_m0_addr), .i_m0_data(a_m0_wdata),
    .i_m1_req(a_m1_req), .i_m1_we(a_m1_we), .i_m1_addr(a_m1_addr), .i_m1_data(a_m1_wdata),
    .o_m0_ack(a_m0_ack), .o_m0_data(a_m0_rdata),
    .o_m1_ack(a_m1_ack), .o_m1_data(a_m1_rdata),
    .o_we(a_we), .o_addr(a_addr), .o_data(a_odata), .i_data(a_idata),
    .o_busy(a_busy)
  );

  // Five-register slave with registered read data.
  logic [7:0] sregs [8];
  initial begin
    for (int i = 0; i < 8; i++) sregs[i] = 8'h00;
    a_idata = 8'h00;
  end
  always @(posedge clk) begin
    if (a_we && a_addr < 8'd5) sregs[a_addr[2:0]] <= a_odata;
    a_idata <= (a_addr < 8'd5) ? sregs[a_addr[2:0]] : 8'h00;
  end

  // ---------------- RD_LAT = 3 instance ----------------
  logic       rst3;
  logic       b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [7:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic       b_m0_ack, b_m1_ack, b_we, b_busy;
  logic [7:0] b_m0_rdata, b_m1_rdata, b_addr, b_odata, b_idata;

  bus_arb2 #(.DATAW(8), .RD_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst(rst3),
    .i_m0_req(b_m0_req), .i_m0_we(b_m0_we), .i_m0_addr(b_m0_addr), .i_m0_data(b_m0_wdata),
    .i_m1_req(b_m1_req), .i_m1_we(b_m1_we), .i_m1_addr(b_m1_addr), .i_m1_data(b_m1_wdata),
    .o_m0_ack(b_m0_ack), .o_m0_data(b_m0_rdata),
    .o_m1_ack(b_m1_ack), .o_m1_data(b_m1_rdata),
    .o_we(b_we), .o_addr(b_addr), .o_data(b_odata), .i_data(b_idata),
    .o_busy(b_busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    b_idata = 8'h00;
    step(); step();

    // Reset state
    chk("rst_busy",   32'(a_busy), 32'h0);
    chk("rst_we",     32'(a_we), 32'h0);
    chk("rst_addr",   32'(a_addr), 32'h0);
    chk("rst_odata",  32'(a_odata), 32'h0);
    chk("rst_m0data", 32'(a_m0_rdata), 32'h0);
    chk("rst_m1data", 32'(a_m1_rdata), 32'h0);
    chk("rst_m0ack",  32'(a_m0_ack), 32'h0);
    chk("rst_m1ack",  32'(a_m1_ack), 32'h0);
    chk("rst3_busy",  32'(b_busy), 32'h0);
    rst1 = 1'b0; rst3 = 1'b0;
    step();

    // Single write: m0 writes 0xA5 to addr 2 (cycle G)
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 8'h02; a_m0_wdata = 8'hA5;
    chk("wr_g_busy", 32'(a_busy), 32'h0);
    step(); // G+1
    chk("wr_issue_we",   32'(a_we), 32'h1);
    chk("wr_issue_addr", 32'(a_addr), 32'h02);
    chk("wr_issue_data", 32'(a_odata), 32'hA5);
    chk("wr_issue_busy", 32'(a_busy), 32'h1);
    chk("wr_issue_ack",  32'(a_m0_ack), 32'h0);
    a_m0_wdata = 8'hFF; // mid-flight change must be ignored
    step(); // G+2
    chk("wr_ack_m0",    32'(a_m0_ack), 32'h1);
    chk("wr_ack_m1",    32'(a_m1_ack), 32'h0);
    chk("wr_ack_we",    32'(a_we), 32'h0);
    chk("wr_ack_odata", 32'(a_odata), 32'hA5);
    chk("wr_m0data",    32'(a_m0_rdata), 32'h00);
    a_m0_req = 0;
    step(); // G+3
    chk("wr_idle_ack",  32'(a_m0_ack), 32'h0);
    chk("wr_idle_busy", 32'(a_busy), 32'h0);
    chk("wr_idle_addr", 32'(a_addr), 32'h02);

    // Read-back: m1 reads addr 2 (cycle G')
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 8'h02;
    step(); // G'+1
    chk("rd_issue_we",   32'(a_we), 32'h0);
    chk("rd_issue_addr", 32'(a_addr), 32'h02);
    step(); // G'+2
    chk("rd_wait_ack",   32'(a_m1_ack), 32'h0);
    chk("rd_wait_busy",  32'(a_busy), 32'h1);
    step(); // G'+3
    chk("rd_ack_m1",     32'(a_m1_ack), 32'h1);
    chk("rd_ack_m0",     32'(a_m0_ack), 32'h0);
    chk("rd_m1data",     32'(a_m1_rdata), 32'hA5);
    chk("rd_m0data",     32'(a_m0_rdata), 32'h00);
    a_m1_req = 0;
    step();

    // Contention from reset release
    rst1 = 1'b1;
    step();
    chk("rst2_m1data", 32'(a_m1_rdata), 32'h00);
    chk("rst2_busy",   32'(a_busy), 32'h0);
    rst1 = 1'b0;
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 8'h00; a_m0_wdata = 8'h11;
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 8'h01; a_m1_wdata = 8'h22;
    step(); // G+1
    chk("ct1_addr", 32'(a_addr), 32'h00);
    chk("ct1_data", 32'(a_odata), 32'h11);
    chk("ct1_we",   32'(a_we), 32'h1);
    step(); // G+2
    chk("ct1_m0ack", 32'(a_m0_ack), 32'h1);
    chk("ct1_m1ack", 32'(a_m1_ack), 32'h0);
    a_m0_req = 0;
    step(); // G+3
    chk("ct_idle_busy", 32'(a_busy), 32'h0);
    step(); // G+4
    chk("ct2_addr", 32'(a_addr), 32'h01);
    chk("ct2_data", 32'(a_odata), 32'h22);
    chk("ct2_we",   32'(a_we), 32'h1);
    step(); // G+5
    chk("ct2_m1ack", 32'(a_m1_ack), 32'h1);
    chk("ct2_m0ack", 32'(a_m0_ack), 32'h0);
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 8'h03; a_m0_wdata = 8'h33;
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 8'h04; a_m1_wdata = 8'h44;
    step(); // G+6 idle, both requesting
    chk("ct3_idle_busy", 32'(a_busy), 32'h0);
    step(); // G+7
    chk("ct3_addr", 32'(a_addr), 32'h03);
    chk("ct3_data", 32'(a_odata), 32'h33);
    step(); // G+8
    chk("ct3_m0ack", 32'(a_m0_ack), 32'h1);
    chk("ct3_m1ack", 32'(a_m1_ack), 32'h0);
    a_m0_req = 0; a_m1_req = 0;
    step();
    chk("ct_end_busy", 32'(a_busy), 32'h0);

    // Back-to-back on m0: write then read of addr 3 with req held
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 8'h03; a_m0_wdata = 8'h5A;
    step(); // B+1
    chk("bb_wr_we",   32'(a_we), 32'h1);
    chk("bb_wr_addr", 32'(a_addr), 32'h03);
    step(); // B+2
    chk("bb_wr_ack",  32'(a_m0_ack), 32'h1);
    step(); // B+3 IDLE, new command
    chk("bb_idle_ack",  32'(a_m0_ack), 32'h0);
    chk("bb_idle_busy", 32'(a_busy), 32'h0);
    a_m0_we = 0;
    step(); // B+4
    chk("bb_rd_busy", 32'(a_busy), 32'h1);
    chk("bb_rd_we",   32'(a_we), 32'h0);
    chk("bb_rd_addr", 32'(a_addr), 32'h03);
    step(); // B+5
    chk("bb_rd_wait_ack", 32'(a_m0_ack), 32'h0);
    step(); // B+6
    chk("bb_rd_ack",    32'(a_m0_ack), 32'h1);
    chk("bb_m0data",    32'(a_m0_rdata), 32'h5A);
    chk("bb_m1data",    32'(a_m1_rdata), 32'h00);
    a_m0_req = 0;
    step();

    // RD_LAT=3 read by m1 of addr 4 (cycle H)
    b_m1_req = 1; b_m1_we = 0; b_m1_addr = 8'h04;
    step(); // H+1 ISSUE
    b_idata = 8'h10;
    chk("l3_issue_addr", 32'(b_addr), 32'h04);
    chk("l3_issue_busy", 32'(b_busy), 32'h1);
    chk("l3_issue_we",   32'(b_we), 32'h0);
    step(); // H+2 WAIT 1
    b_idata = 8'h20; b_m1_addr = 8'h07;
    chk("l3_w1_addr", 32'(b_addr), 32'h04);
    chk("l3_w1_ack",  32'(b_m1_ack), 32'h0);
    step(); // H+3 WAIT 2
    b_idata = 8'h30;
    chk("l3_w2_addr", 32'(b_addr), 32'h04);
    chk("l3_w2_ack",  32'(b_m1_ack), 32'h0);
    step(); // H+4 WAIT 3
    b_idata = 8'h40;
    chk("l3_w3_addr",   32'(b_addr), 32'h04);
    chk("l3_w3_ack",    32'(b_m1_ack), 32'h0);
    chk("l3_w3_m1data", 32'(b_m1_rdata), 32'h00);
    step(); // H+5 ACK
    chk("l3_ack_m1",    32'(b_m1_ack), 32'h1);
    chk("l3_m1data",    32'(b_m1_rdata), 32'h40);
    chk("l3_m0data",    32'(b_m0_rdata), 32'h00);
    b_m1_req = 0;
    step();

    // Reset mid-read on RD_LAT=3 instance (cycle K)
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 8'h01; b_idata = 8'h77;
    step(); // K+1 ISSUE
    chk("rr_issue_busy", 32'(b_busy), 32'h1);
    step(); // K+2 WAIT
    rst3 = 1'b1;
    step(); // K+3 IDLE after reset, release now
    chk("rr_rst_busy",   32'(b_busy), 32'h0);
    chk("rr_rst_m0ack",  32'(b_m0_ack), 32'h0);
    chk("rr_rst_m0data", 32'(b_m0_rdata), 32'h00);
    chk("rr_rst_m1data", 32'(b_m1_rdata), 32'h00);
    chk("rr_rst_addr",   32'(b_addr), 32'h00);
    rst3 = 1'b0;
    step(); // K+4 ISSUE
    chk("rr_re_busy", 32'(b_busy), 32'h1);
    chk("rr_re_addr", 32'(b_addr), 32'h01);
    step(); // K+5
    step(); // K+6
    step(); // K+7 last WAIT
    chk("rr_w_ack",    32'(b_m0_ack), 32'h0);
    chk("rr_w_m0data", 32'(b_m0_rdata), 32'h00);
    step(); // K+8 ACK
    chk("rr_ack_m0",   32'(b_m0_ack), 32'h1);
    chk("rr_m0data",   32'(b_m0_rdata), 32'h77);
    b_m0_req = 0;
    step();
    chk("rr_end_busy", 32'(b_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb2.md
BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 Parameter DATAW, default 8: data width of both masters and of the slave port.
REQ-002 Parameter RD_LAT, default 1, legal 1..4: cycles from the end of ISSUE until slave read data is valid on i_data.
REQ-003 i_clk  in  1  single clock; all logic on the rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_m0_req, i_m1_req  in  1 each  master transaction request; held with its command until ack.
REQ-006 i_m0_we, i_m1_we  in  1 each  1 = write, 0 = read.
REQ-007 i_m0_addr, i_m1_addr  in  8 each  register address.
REQ-008 i_m0_data, i_m1_data  in  DATAW each  write data.
REQ-009 o_m0_ack, o_m1_ack  out  1 each  one-cycle completion pulse.
REQ-010 o_m0_data, o_m1_data  out  DATAW each  read data returned to that master.
REQ-011 o_we  out  1  slave write enable.
REQ-012 o_addr  out  8  slave address.
REQ-013 o_data  out  DATAW  slave write data.
REQ-014 i_data  in  DATAW  slave registered read data.
REQ-015 o_busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; all outputs registered or decoded from state and registers only, with no combinational path from any input to any output.
REQ-017 IDLE: if any req is high, SHALL grant one master, latch its we/addr/data into the command register, record the granted index, and go to ISSUE; else stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: if both req are high, grant the master not granted last; if one req is high, grant it regardless of history.
REQ-019 ISSUE: o_addr/o_data SHALL drive the latched command and o_we the latched we, for exactly one cycle; next state is WAIT for a read, ACK for a write.
REQ-020 o_we SHALL be high only in ISSUE with a latched write; it is 0 in all other states.
REQ-021 WAIT SHALL last exactly RD_LAT cycles with o_addr held; at the end of its last cycle, i_data SHALL be captured into the granted master's o_mN_data; then go to ACK.
REQ-022 ACK: the granted master's o_mN_ack SHALL be 1 for exactly this cycle and the other ack 0; next state is IDLE.
REQ-023 Latency, req first high in cycle G while IDLE: write ack in G+2; read ack in G+2+RD_LAT.
REQ-024 The master SHALL have deasserted req, or presented a new command, by the cycle after ack; req high in that IDLE cycle SHALL start a new transaction (back-to-back allowed).
REQ-025 o_mN_data SHALL change only on a read capture for master N; write completions and the other master's reads leave it unchanged.
REQ-026 Changes to any master input while not in IDLE SHALL have no effect on the transaction in flight.
REQ-027 o_addr and o_data SHALL hold the last latched command in IDLE; the slave's read path therefore remains pointed at the last address.

Reset
REQ-028 While i_rst is high: state SHALL go to IDLE, o_we/o_m0_ack/o_m1_ack/o_busy SHALL be 0, o_addr/o_data/o_m0_data/o_m1_data SHALL be 0, and last-granted SHALL be master 1, so master 0 wins the first contention.
REQ-029 Reset in any state SHALL abort the transaction: no ack, no o_we, no data capture; a req held through reset SHALL be arbitrated in the first IDLE cycle after release.

Verification
REQ-030 Single write, RD_LAT=1: m0 writes addr 0x02, data 0xA5 at cycle G -> o_we=1 with o_addr=0x02 and o_data=0xA5 in G+1 only; o_m0_ack pulse in G+2; o_m0_data unchanged.
REQ-031 Read-back with the five-register slave, RD_LAT=1: after the REQ-030 write, m1 reads addr 0x02 -> o_m1_ack in G'+3 with o_m1_data=0xA5; o_m0_data still 0x00.
REQ-032 Contention: both req high from reset release, m0 writes 0x11 to addr 0, m1 writes 0x22 to addr 1, each holding req until its ack -> m0 acked first, then m1; a third simultaneous request pair is granted to m0 again.
REQ-033 RD_LAT=3 read: o_addr stable for ISSUE plus 3 WAIT cycles; ack in G+5; the captured value is i_data from the last WAIT cycle, not earlier ones.
REQ-034 Reset mid-read (assert in WAIT): no ack is pulsed and o_mN_data stays 0; with req held, the transaction restarts and completes with the normal latency after release.
REQ-035 Back-to-back: m0 keeps req high and changes the command in the cycle after ack -> the new transaction is granted in that IDLE cycle and its ack follows at the normal latency.
